sram_ctl_s3board: RTL and testbench

SRAM_CTL_S3BOARD -- requirements
Module: sram_ctl_s3board

---
 rtl/sram_ctl_s3board.sv | 229 ++++++++++++++++++++++
 tb/tb_sram_ctl_s3board.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctl_s3board.sv
// sram_ctl_s3board: single-access controller for the two 256Kx16 asynchronous
// SRAMs on the Spartan-3 starter board. One request is handled at a time; the
// word address bit 18 picks the chip, and every pin toward the SRAMs and the
// host is driven straight from a flop so the board sees glitch-free strobes.
module sram_ctl_s3board #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [18:0] addr,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [17:0] ram_a,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  inout  wire  [15:0] ram1_io,
  inout  wire  [15:0] ram2_io,
  output logic        ram1_ce_n,
  output logic        ram1_ub_n,
  output logic        ram1_lb_n,
  output logic        ram2_ce_n,
  output logic        ram2_ub_n,
  output logic        ram2_lb_n
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WS   = 3'd2,
    S_WP   = 3'd3,
    S_WH   = 3'd4,
    S_ACK  = 3'd5
  } state_t;

  // The wait counter counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 32'd1);

  // Keep only the enabled byte lanes of a word; disabled lanes read as zero.
  function automatic logic [15:0] lane_mask(input logic [15:0] word, input logic [1:0] lanes);
    lane_mask = {(lanes[1] ? word[15:8] : 8'h00), (lanes[0] ? word[7:0] : 8'h00)};
  endfunction

  // Active-low {ce_n, ub_n, lb_n} for one chip.
  function automatic logic [2:0] chip_selects(input logic enable, input logic [1:0] lanes);
    chip_selects = enable ? {1'b0, ~lanes[1], ~lanes[0]} : 3'b111;
  endfunction

  // FSM state, wait counter and the request latched in IDLE.
  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [18:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;

  // Registered outputs and io drive enables.
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [17:0] ram_a_q, ram_a_d;
  logic        ram_oe_n_q, ram_oe_n_d;
  logic        ram_we_n_q, ram_we_n_d;
  logic [2:0]  ram1_sel_n_q, ram1_sel_n_d;
  logic [2:0]  ram2_sel_n_q, ram2_sel_n_d;
  logic        ram1_drv_q, ram1_drv_d;
  logic        ram2_drv_q, ram2_drv_d;

  // Decode helpers for the output logic.
  logic        active_s;
  logic        wr_phase_s;
  logic        rd_last_s;
  logic [15:0] rd_bus_s;

  // State register: FSM state, wait counter and latched request fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= 19'd0;
      be_q       <= 2'b00;
      wdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next state: accept a request only in IDLE, then time the strobes.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          be_d    = be;
          wdata_d = wdata;
          if (be == 2'b00) begin
            // Nothing to transfer: acknowledge without touching the SRAMs.
            state_d = S_ACK;
          end else if (we) begin
            state_d = S_WS;
          end else begin
            state_d    = S_RD;
            wait_cnt_d = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_WS: begin
        // Address and data settle one cycle before the write pulse.
        state_d    = S_WP;
        wait_cnt_d = WAIT_LOAD;
      end
      S_WP: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = S_WH;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_WH: begin
        // Data held one cycle after we_n rises.
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode for the state being entered, so registered pins track state_q.
  always_comb begin
    active_s   = (state_d == S_RD) || (state_d == S_WS) ||
                 (state_d == S_WP) || (state_d == S_WH);
    wr_phase_s = (state_d == S_WS) || (state_d == S_WP) || (state_d == S_WH);
    rd_last_s  = (state_q == S_RD) && (wait_cnt_q == 4'd0);
    rd_bus_s   = addr_q[18] ? ram2_io : ram1_io;

    ack_d      = (state_d == S_ACK);
    busy_d     = (state_d != S_IDLE);
    ram_oe_n_d = (state_d != S_RD);
    ram_we_n_d = (state_d != S_WP);

    if (active_s) begin
      ram_a_d = addr_d[17:0];
    end else begin
      ram_a_d = ram_a_q;
    end

    ram1_sel_n_d = chip_selects(active_s && !addr_d[18], be_d);
    ram2_sel_n_d = chip_selects(active_s && addr_d[18], be_d);
    ram1_drv_d   = wr_phase_s && !addr_d[18];
    ram2_drv_d   = wr_phase_s && addr_d[18];

    // Capture the read word on the edge that ends the last RD cycle.
    if (rd_last_s) begin
      rdata_d = lane_mask(rd_bus_s, be_q);
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output register: every host and SRAM pin comes from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q      <= 16'h0000;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      ram_a_q      <= 18'd0;
      ram_oe_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
      ram1_sel_n_q <= 3'b111;
      ram2_sel_n_q <= 3'b111;
      ram1_drv_q   <= 1'b0;
      ram2_drv_q   <= 1'b0;
    end else begin
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      ram_a_q      <= ram_a_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_we_n_q   <= ram_we_n_d;
      ram1_sel_n_q <= ram1_sel_n_d;
      ram2_sel_n_q <= ram2_sel_n_d;
      ram1_drv_q   <= ram1_drv_d;
      ram2_drv_q   <= ram2_drv_d;
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign ram_a     = ram_a_q;
  assign ram_oe_n  = ram_oe_n_q;
  assign ram_we_n  = ram_we_n_q;
  assign ram1_ce_n = ram1_sel_n_q[2];
  assign ram1_ub_n = ram1_sel_n_q[1];
  assign ram1_lb_n = ram1_sel_n_q[0];
  assign ram2_ce_n = ram2_sel_n_q[2];
  assign ram2_ub_n = ram2_sel_n_q[1];
  assign ram2_lb_n = ram2_sel_n_q[0];

  // Only the selected chip's bus is driven, and only during a write.
  assign ram1_io = ram1_drv_q ? wdata_q : 16'hzzzz;
  assign ram2_io = ram2_drv_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctl_s3board.sv
// tb_sram_ctl_s3board: directed and random accesses against a word-level
// memory model; latencies, strobe counts and read data come from the
// access rules, not from the controller's internals.
module tb_sram_ctl_s3board;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [18:0] addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic [17:0] ram_a;
  logic        ram_oe_n, ram_we_n;
  wire  [15:0] ram1_io, ram2_io;
  logic        ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n;

  int n_checks = 0;
  int n_errors = 0;

  // Board SRAM model (aliased on the low 10 address bits) and reference memory.
  logic [15:0] sram1 [0:1023];
  logic [15:0] sram2 [0:1023];
  logic [15:0] ref1  [0:1023];
  logic [15:0] ref2  [0:1023];
  logic [15:0] exp_rdata;
  logic [15:0] got;
  bit          mem_init;

  sram_ctl_s3board #(.WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .ram_a(ram_a),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram1_io(ram1_io), .ram2_io(ram2_io),
    .ram1_ce_n(ram1_ce_n), .ram1_ub_n(ram1_ub_n), .ram1_lb_n(ram1_lb_n),
    .ram2_ce_n(ram2_ce_n), .ram2_ub_n(ram2_ub_n), .ram2_lb_n(ram2_lb_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input logic chip, input logic [9:0] idx);
    return 16'hA5C3 ^ {5'd0, chip, idx};
  endfunction

  // A bus counts as driven when it carries anything other than float/zero.
  function automatic bit bus_driven(input logic [15:0] v);
    return (v !== 16'h0000) && (v !== 16'hzzzz);
  endfunction

  // The model drives the full word on reads so lane masking in the controller is visible.
  assign ram1_io = (!ram1_ce_n && !ram_oe_n && ram_we_n) ? sram1[ram_a[9:0]] : 16'hzzzz;
  assign ram2_io = (!ram2_ce_n && !ram_oe_n && ram_we_n) ? sram2[ram_a[9:0]] : 16'hzzzz;

  // SRAM storage: initial fill, then byte writes while ce_n and we_n are low.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) begin
        sram1[i] <= init_word(1'b0, 10'(i));
        sram2[i] <= init_word(1'b1, 10'(i));
      end
    end else begin
      if (!ram1_ce_n && !ram_we_n) begin
        if (!ram1_ub_n) sram1[ram_a[9:0]][15:8] <= ram1_io[15:8];
        if (!ram1_lb_n) sram1[ram_a[9:0]][7:0]  <= ram1_io[7:0];
      end
      if (!ram2_ce_n && !ram_we_n) begin
        if (!ram2_ub_n) sram2[ram_a[9:0]][15:8] <= ram2_io[15:8];
        if (!ram2_lb_n) sram2[ram_a[9:0]][7:0]  <= ram2_io[7:0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access from request to the cycle after ack, checked against the access rules.
  task automatic do_access(input logic t_we, input logic [18:0] t_addr, input logic [1:0] t_be,
                           input logic [15:0] t_wdata, input bit hold, output logic [15:0] got_rd);
    int lat, we_lo, oe_lo, sel_ce, other_sel, other_drv, busy_gap, a_err, bsel_err, sel_drv, extra;
    int exp_lat, exp_we, exp_oe, exp_ce;
    bit got_ack;
    logic c;
    logic [9:0] ix;
    logic [15:0] cur, sel_bus;
    c = t_addr[18];
    ix = t_addr[9:0];
    lat = 0; we_lo = 0; oe_lo = 0; sel_ce = 0; other_sel = 0; other_drv = 0;
    busy_gap = 0; a_err = 0; bsel_err = 0; sel_drv = 0; extra = 0; got_ack = 1'b0;
    if (t_be == 2'b00) begin
      exp_lat = 1; exp_we = 0; exp_oe = 0; exp_ce = 0;
    end else if (t_we) begin
      exp_lat = WAIT + 3; exp_we = WAIT; exp_oe = 0; exp_ce = WAIT + 2;
    end else begin
      exp_lat = WAIT + 1; exp_we = 0; exp_oe = WAIT; exp_ce = WAIT;
    end

    @(negedge clk);
    req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wdata;
    @(posedge clk);
    while (!got_ack && lat < 64) begin
      @(negedge clk);
      lat++;
      // Inputs other than the original request must be ignored while busy.
      req = hold; we = 1'($urandom); addr = 19'($urandom); be = 2'($urandom); wdata = 16'($urandom);
      if (ack) begin
        got_ack = 1'b1;
        req = 1'b0;
      end else begin
        sel_bus = c ? ram2_io : ram1_io;
        if (!busy) busy_gap++;
        if (!ram_we_n) we_lo++;
        if (!ram_oe_n) oe_lo++;
        if (c ? {ram1_ce_n, ram1_ub_n, ram1_lb_n} != 3'b111 : {ram2_ce_n, ram2_ub_n, ram2_lb_n} != 3'b111)
          other_sel++;
        if (bus_driven(c ? ram1_io : ram2_io)) other_drv++;
        if ((c ? ram2_ce_n : ram1_ce_n) == 1'b0) begin
          sel_ce++;
          if (ram_a !== t_addr[17:0]) a_err++;
          if ((c ? {ram2_ub_n, ram2_lb_n} : {ram1_ub_n, ram1_lb_n}) !== ~t_be) bsel_err++;
          if (t_we && sel_bus === t_wdata) sel_drv++;
        end
      end
    end

    check("latency", lat, exp_lat);
    check("busy_hold", busy_gap, 0);
    check("we_n_low_cycles", we_lo, exp_we);
    check("oe_n_low_cycles", oe_lo, exp_oe);
    check("sel_ce_cycles", sel_ce, exp_ce);
    check("other_chip_quiet", other_sel + other_drv, 0);
    check("ram_a", a_err, 0);
    check("byte_selects", bsel_err, 0);
    if (t_we && t_be != 2'b00) check("write_bus_drive", sel_drv, WAIT + 2);
    check("ack_busy", busy, 1'b1);
    check("ack_pins_idle", {ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n,
                            ram_oe_n, ram_we_n}, 8'hFF);

    // Reference model: word-level memory with byte enables.
    cur = c ? ref2[ix] : ref1[ix];
    if (t_be != 2'b00) begin
      if (t_we) begin
        if (t_be[1]) cur[15:8] = t_wdata[15:8];
        if (t_be[0]) cur[7:0]  = t_wdata[7:0];
        if (c) ref2[ix] = cur; else ref1[ix] = cur;
      end else begin
        exp_rdata = {(t_be[1] ? cur[15:8] : 8'h00), (t_be[0] ? cur[7:0] : 8'h00)};
      end
    end
    check("rdata_at_ack", rdata, exp_rdata);
    got_rd = rdata;

    @(negedge clk);
    check("ack_one_cycle", {ack, busy}, 2'b00);
    check("rdata_held", rdata, exp_rdata);
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        if (ack || busy || !ram1_ce_n || !ram2_ce_n) extra++;
      end
      check("no_queued_access", extra, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = 19'd0; be = 2'b00; wdata = 16'h0000;
    mem_init = 1'b1;
    exp_rdata = 16'h0000;
    for (int i = 0; i < 1024; i++) begin
      ref1[i] = init_word(1'b0, 10'(i));
      ref2[i] = init_word(1'b1, 10'(i));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack_busy", {ack, busy}, 2'b00);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_ram_a", ram_a, 18'd0);
    check("reset_pins", {ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n,
                         ram_oe_n, ram_we_n}, 8'hFF);
    check("reset_io_float", {30'd0, bus_driven(ram1_io), bus_driven(ram2_io)}, 0);
    mem_init = 1'b0;
    reset_n = 1'b1;

    // Full-word write then read back.
    do_access(1'b1, 19'h00010, 2'b11, 16'o123456, 1'b0, got);
    do_access(1'b0, 19'h00010, 2'b11, 16'h0000, 1'b0, got);
    check("wr_rd_word", got, 16'o123456);

    // Upper-byte write over an existing word.
    do_access(1'b1, 19'h00020, 2'b11, 16'h1234, 1'b0, got);
    do_access(1'b1, 19'h00020, 2'b10, 16'hAB00, 1'b0, got);
    do_access(1'b0, 19'h00020, 2'b11, 16'h0000, 1'b0, got);
    check("byte_merge", got, 16'hAB34);
    do_access(1'b0, 19'h00020, 2'b01, 16'h0000, 1'b0, got);
    check("lane_mask_read", got, 16'h0034);

    // Chip selection by address bit 18.
    do_access(1'b1, 19'h00005, 2'b11, 16'h1111, 1'b0, got);
    do_access(1'b1, 19'h40005, 2'b11, 16'hBEEF, 1'b0, got);
    do_access(1'b0, 19'h00005, 2'b11, 16'h0000, 1'b0, got);
    check("chip1_untouched", got, 16'h1111);
    do_access(1'b0, 19'h40005, 2'b11, 16'h0000, 1'b0, got);
    check("chip2_word", got, 16'hBEEF);

    // Empty byte enable, and req held high through a busy access.
    do_access(1'b0, 19'h00010, 2'b00, 16'h0000, 1'b0, got);
    check("be00_rdata_kept", got, 16'hBEEF);
    do_access(1'b1, 19'h00011, 2'b00, 16'h7777, 1'b1, got);
    do_access(1'b0, 19'h00010, 2'b11, 16'h0000, 1'b1, got);
    do_access(1'b1, 19'h00012, 2'b11, 16'h3C3C, 1'b1, got);

    // Reset pulse in the middle of a write pulse.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 19'h00033; be = 2'b11; wdata = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("ws_we_n", ram_we_n, 1'b1);
    @(negedge clk);
    check("wp_we_n", ram_we_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_we_n", ram_we_n, 1'b1);
    check("rst_ack_busy", {ack, busy}, 2'b00);
    check("rst_pins", {ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n, ram_oe_n}, 7'h7F);
    check("rst_io_float", {30'd0, bus_driven(ram1_io), bus_driven(ram2_io)}, 0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_ram_a", ram_a, 18'd0);
    exp_rdata = 16'h0000;
    begin
      int quiet_err;
      quiet_err = 0;
      repeat (3) begin
        @(negedge clk);
        if (ack || busy || !ram_we_n) quiet_err++;
      end
      reset_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (ack || busy) quiet_err++;
      end
      check("rst_no_ack", quiet_err, 0);
    end
    do_access(1'b1, 19'h00033, 2'b11, 16'hC3C3, 1'b0, got);
    do_access(1'b0, 19'h00033, 2'b11, 16'h0000, 1'b0, got);
    check("post_reset_write", got, 16'hC3C3);

    // Random accesses over a small set of words so reads hit earlier writes.
    for (int k = 0; k < 40; k++) begin
      do_access(1'($urandom), {1'($urandom), 8'($urandom), 10'($urandom_range(0, 7))},
                2'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
